// File: rtl/prog_run_ctrl_if.sv
// Bundle of the job, data-memory, core and result signals of the program-run controller.
// Valid/ready: a transfer happens on a rising edge where both valid and ready are 1;
// the source keeps valid and data stable until that edge; ready may depend on state only.
interface prog_run_ctrl_if;
  logic        job_valid;
  logic [15:0] job_data;
  logic        job_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        core_req;
  logic        core_ack;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_timeout;
  logic        res_ready;

  modport master (
    input  job_valid, job_data, mem_rdata, core_ack, res_ready,
    output job_ready, mem_we, mem_addr, mem_wdata, core_req,
           res_valid, res_data, res_timeout
  );

  modport slave (
    output job_valid, job_data, mem_rdata, core_ack, res_ready,
    input  job_ready, mem_we, mem_addr, mem_wdata, core_req,
           res_valid, res_data, res_timeout
  );
endinterface

// File: rtl/prog_run_ctrl.sv
// Runs one job on a processor core: writes the operand to data memory, pulses the core,
// waits (bounded) for completion, reads back the result and offers it on a valid/ready port.
module prog_run_ctrl #(
  parameter int IN_ADDR  = 4,
  parameter int OUT_ADDR = 6,
  parameter int TIMEOUT  = 4096
) (
  input  logic              clk,
  input  logic              reset,
  prog_run_ctrl_if.master   bus,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR_HI = 3'd1,
    S_WR_LO = 3'd2,
    S_REQ   = 3'd3,
    S_WAIT  = 3'd4,
    S_RD_HI = 3'd5,
    S_RD_LO = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);
  localparam logic [7:0]  IN_HI    = 8'(IN_ADDR);
  localparam logic [7:0]  IN_LO    = 8'(IN_ADDR + 1);
  localparam logic [7:0]  OUT_HI   = 8'(OUT_ADDR);
  localparam logic [7:0]  OUT_LO   = 8'(OUT_ADDR + 1);

  state_t      state_q, state_d;
  logic        run_q, run_d;
  logic [15:0] job_q, job_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] res_data_q, res_data_d;
  logic        res_timeout_q, res_timeout_d;

  // run_q keeps job_ready low while reset is held and rises on the first edge after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      run_q         <= 1'b0;
      job_q         <= 16'h0000;
      cnt_q         <= 16'h0000;
      res_data_q    <= 16'h0000;
      res_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      run_q         <= run_d;
      job_q         <= job_d;
      cnt_q         <= cnt_d;
      res_data_q    <= res_data_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    run_d         = 1'b1;
    job_d         = job_q;
    cnt_d         = cnt_q;
    res_data_d    = res_data_q;
    res_timeout_d = res_timeout_q;
    case (state_q)
      S_IDLE: begin
        if (run_q && bus.job_valid) begin
          job_d   = bus.job_data;
          state_d = S_WR_HI;
        end
      end
      S_WR_HI: state_d = S_WR_LO;
      S_WR_LO: state_d = S_REQ;
      S_REQ: begin
        cnt_d   = 16'h0000;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // An ack on the last allowed cycle takes priority over the timeout.
        if (bus.core_ack) begin
          state_d = S_RD_HI;
        end else if (cnt_q == CNT_LAST) begin
          res_timeout_d = 1'b1;
          res_data_d    = 16'h0000;
          state_d       = S_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RD_HI: begin
        res_data_d[15:8] = bus.mem_rdata;
        state_d          = S_RD_LO;
      end
      S_RD_LO: begin
        res_data_d[7:0] = bus.mem_rdata;
        res_timeout_d   = 1'b0;
        state_d         = S_DONE;
      end
      S_DONE: begin
        if (bus.res_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    bus.job_ready = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 8'h00;
    bus.mem_wdata = 8'h00;
    bus.core_req  = 1'b0;
    bus.res_valid = 1'b0;
    case (state_q)
      S_IDLE:  bus.job_ready = run_q;
      S_WR_HI: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = IN_HI;
        bus.mem_wdata = job_q[15:8];
      end
      S_WR_LO: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = IN_LO;
        bus.mem_wdata = job_q[7:0];
      end
      S_REQ:   bus.core_req  = 1'b1;
      S_WAIT:  bus.mem_addr  = 8'h00;
      S_RD_HI: bus.mem_addr  = OUT_HI;
      S_RD_LO: bus.mem_addr  = OUT_LO;
      S_DONE:  bus.res_valid = 1'b1;
    endcase
  end

  assign bus.res_data    = res_data_q;
  assign bus.res_timeout = res_timeout_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Directed bench for prog_run_ctrl: data-memory and core models, one task per scenario,
// expected values worked out by hand from the controller's cycle timing.
module tb_prog_run_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] state_dbg;

  prog_run_ctrl_if bus();

  prog_run_ctrl #(.IN_ADDR(4), .OUT_ADDR(6), .TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int wr_count = 0;
  int req_count = 0;

  // data memory; bytes 6/7 reflect what the core model leaves as its result
  logic [7:0]  mem [256];
  logic [15:0] core_res = 16'h0000;
  logic        core_add = 1'b0;
  logic [15:0] core_word;
  assign core_word = core_add ? ({mem[4], mem[5]} + 16'd1) : core_res;
  assign bus.mem_rdata = (bus.mem_addr == 8'd6) ? core_word[15:8] :
                         (bus.mem_addr == 8'd7) ? core_word[7:0] : mem[bus.mem_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      wr_count <= wr_count + 1;
    end
    if (bus.core_req) req_count <= req_count + 1;
  end

  // core model: ack ack_delay cycles after the core_req cycle (0 = never)
  int   ack_delay = 0;
  int   ack_cnt = 0;
  logic model_ack = 1'b0;
  logic late_ack = 1'b0;
  assign bus.core_ack = model_ack | late_ack;

  always @(negedge clk) begin
    model_ack = 1'b0;
    if (ack_cnt > 0) begin
      ack_cnt = ack_cnt - 1;
      if (ack_cnt == 0) model_ack = 1'b1;
    end
    if (bus.core_req && ack_delay > 0) ack_cnt = ack_delay;
  end

  logic [15:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic send_job(input logic [15:0] d, output int acc);
    acc = -1;
    @(negedge clk);
    bus.job_valid = 1'b1;
    bus.job_data  = d;
    for (int i = 0; i < 50 && acc < 0; i++) begin
      if (bus.job_ready) acc = cyc;
      @(negedge clk);
    end
    bus.job_valid = 1'b0;
    if (acc < 0) begin
      miscompares++;
      $display("FAIL job_accept: job %h not accepted within 50 cycles", d);
    end
  endtask

  task automatic wait_valid(output int vcyc);
    vcyc = -1;
    for (int i = 0; i < 100 && vcyc < 0; i++) begin
      if (bus.res_valid) vcyc = cyc;
      else @(negedge clk);
    end
    if (vcyc < 0) begin
      miscompares++;
      $display("FAIL res_valid_wait: no result within 100 cycles");
    end
  endtask

  task automatic release_result();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    vectors++;
    if (bus.res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL release_valid: res_valid=%b expected 0", bus.res_valid);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.job_valid = 1'b0;
    bus.job_data  = 16'h0000;
    bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    vectors += 9;
    if (bus.job_ready !== 1'b0) begin miscompares++; $display("FAIL rst_job_ready: got %b expected 0", bus.job_ready); end
    if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL rst_res_valid: got %b expected 0", bus.res_valid); end
    if (bus.core_req !== 1'b0) begin miscompares++; $display("FAIL rst_core_req: got %b expected 0", bus.core_req); end
    if (bus.mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_mem_we: got %b expected 0", bus.mem_we); end
    if (bus.mem_addr !== 8'h00) begin miscompares++; $display("FAIL rst_mem_addr: got %h expected 00", bus.mem_addr); end
    if (bus.mem_wdata !== 8'h00) begin miscompares++; $display("FAIL rst_mem_wdata: got %h expected 00", bus.mem_wdata); end
    if (bus.res_data !== 16'h0000) begin miscompares++; $display("FAIL rst_res_data: got %h expected 0000", bus.res_data); end
    if (bus.res_timeout !== 1'b0) begin miscompares++; $display("FAIL rst_res_timeout: got %b expected 0", bus.res_timeout); end
    if (state_dbg !== 3'd0) begin miscompares++; $display("FAIL rst_state: got %0d expected 0", state_dbg); end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.job_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_job_ready: got %b expected 1", bus.job_ready); end
  endtask

  task automatic test_nominal();
    int a, v, w0, r0;
    ack_delay = 10;
    core_add  = 1'b0;
    core_res  = 16'h0001;
    w0 = wr_count;
    r0 = req_count;
    send_job(16'h3C00, a);
    wait_valid(v);
    vectors += 8;
    if (v - a !== 16) begin miscompares++; $display("FAIL nom_latency: got %0d expected 16", v - a); end
    if (bus.res_data !== 16'h0001) begin miscompares++; $display("FAIL nom_res_data: got %h expected 0001", bus.res_data); end
    if (bus.res_timeout !== 1'b0) begin miscompares++; $display("FAIL nom_timeout: got %b expected 0", bus.res_timeout); end
    if (mem[4] !== 8'h3C) begin miscompares++; $display("FAIL nom_mem4: got %h expected 3C", mem[4]); end
    if (mem[5] !== 8'h00) begin miscompares++; $display("FAIL nom_mem5: got %h expected 00", mem[5]); end
    if (wr_count - w0 !== 2) begin miscompares++; $display("FAIL nom_writes: got %0d expected 2", wr_count - w0); end
    if (req_count - r0 !== 1) begin miscompares++; $display("FAIL nom_core_req: got %0d pulses expected 1", req_count - r0); end
    if (bus.job_ready !== 1'b0) begin miscompares++; $display("FAIL nom_busy_ready: got %b expected 0", bus.job_ready); end
    release_result();
  endtask

  task automatic test_timeout();
    int a, v;
    ack_delay = 0;
    core_res  = 16'h5555;
    send_job(16'hABCD, a);
    wait_valid(v);
    vectors += 5;
    if (v - a !== 20) begin miscompares++; $display("FAIL to_latency: got %0d expected 20", v - a); end
    if (bus.res_timeout !== 1'b1) begin miscompares++; $display("FAIL to_flag: got %b expected 1", bus.res_timeout); end
    if (bus.res_data !== 16'h0000) begin miscompares++; $display("FAIL to_res_data: got %h expected 0000", bus.res_data); end
    if (mem[4] !== 8'hAB) begin miscompares++; $display("FAIL to_mem4: got %h expected AB", mem[4]); end
    if (mem[5] !== 8'hCD) begin miscompares++; $display("FAIL to_mem5: got %h expected CD", mem[5]); end
    release_result();
  endtask

  task automatic test_ack_last();
    int a, v;
    ack_delay = 16;
    core_res  = 16'h7FFF;
    send_job(16'h1234, a);
    wait_valid(v);
    vectors += 3;
    if (v - a !== 22) begin miscompares++; $display("FAIL last_latency: got %0d expected 22", v - a); end
    if (bus.res_data !== 16'h7FFF) begin miscompares++; $display("FAIL last_res_data: got %h expected 7FFF", bus.res_data); end
    if (bus.res_timeout !== 1'b0) begin miscompares++; $display("FAIL last_timeout: got %b expected 0", bus.res_timeout); end
    release_result();
  endtask

  task automatic test_backpressure();
    int a, v, h;
    ack_delay = 1;
    core_res  = 16'h0A0B;
    send_job(16'h1111, a);
    wait_valid(v);
    vectors++;
    if (v - a !== 7) begin miscompares++; $display("FAIL bp_latency: got %0d expected 7", v - a); end
    bus.job_valid = 1'b1;
    bus.job_data  = 16'h2222;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors += 3;
      if (bus.res_data !== 16'h0A0B) begin miscompares++; $display("FAIL bp_hold_data: cyc %0d got %h expected 0A0B", i, bus.res_data); end
      if (bus.res_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold_valid: cyc %0d got %b expected 1", i, bus.res_valid); end
      if (bus.job_ready !== 1'b0) begin miscompares++; $display("FAIL bp_job_ready: cyc %0d got %b expected 0", i, bus.job_ready); end
    end
    h = cyc;
    bus.res_ready = 1'b1;
    core_res = 16'h0C0D;
    @(negedge clk);
    bus.res_ready = 1'b0;
    vectors += 3;
    if (cyc - h !== 1) begin miscompares++; $display("FAIL bp_cycle: got %0d expected 1", cyc - h); end
    if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL bp_valid_drop: got %b expected 0", bus.res_valid); end
    if (bus.job_ready !== 1'b1) begin miscompares++; $display("FAIL bp_reaccept: got %b expected 1", bus.job_ready); end
    @(negedge clk);
    bus.job_valid = 1'b0;
    vectors++;
    if (state_dbg !== 3'd1) begin miscompares++; $display("FAIL bp_second_state: got %0d expected 1", state_dbg); end
    wait_valid(v);
    vectors += 3;
    if (bus.res_data !== 16'h0C0D) begin miscompares++; $display("FAIL bp_second_data: got %h expected 0C0D", bus.res_data); end
    if (mem[4] !== 8'h22) begin miscompares++; $display("FAIL bp_mem4: got %h expected 22", mem[4]); end
    if (mem[5] !== 8'h22) begin miscompares++; $display("FAIL bp_mem5: got %h expected 22", mem[5]); end
    release_result();
  endtask

  task automatic test_reset_mid();
    int a, w0, r0;
    ack_delay = 0;
    send_job(16'h5A5A, a);
    repeat (3) @(negedge clk);
    vectors++;
    if (state_dbg !== 3'd4) begin miscompares++; $display("FAIL mid_in_wait: got %0d expected 4", state_dbg); end
    w0 = wr_count;
    r0 = req_count;
    #2 reset = 1'b0;
    #1;
    vectors += 4;
    if (state_dbg !== 3'd0) begin miscompares++; $display("FAIL mid_async_state: got %0d expected 0", state_dbg); end
    if (bus.core_req !== 1'b0) begin miscompares++; $display("FAIL mid_core_req: got %b expected 0", bus.core_req); end
    if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL mid_res_valid: got %b expected 0", bus.res_valid); end
    if (bus.job_ready !== 1'b0) begin miscompares++; $display("FAIL mid_job_ready_rst: got %b expected 0", bus.job_ready); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.job_ready !== 1'b1) begin miscompares++; $display("FAIL mid_job_ready: got %b expected 1", bus.job_ready); end
    late_ack = 1'b1;
    repeat (2) @(negedge clk);
    late_ack = 1'b0;
    @(negedge clk);
    vectors += 5;
    if (state_dbg !== 3'd0) begin miscompares++; $display("FAIL mid_late_ack_state: got %0d expected 0", state_dbg); end
    if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL mid_late_valid: got %b expected 0", bus.res_valid); end
    if (bus.res_data !== 16'h0000) begin miscompares++; $display("FAIL mid_res_data: got %h expected 0000", bus.res_data); end
    if (wr_count !== w0) begin miscompares++; $display("FAIL mid_writes: got %0d expected %0d", wr_count, w0); end
    if (req_count !== r0) begin miscompares++; $display("FAIL mid_core_req_count: got %0d expected %0d", req_count, r0); end
  endtask

  task automatic test_back_to_back();
    int acc[2];
    int n, nres;
    logic upd;
    logic [15:0] e;
    ack_delay = 1;
    core_add  = 1'b1;
    exp_q.push_back(16'h4001);
    exp_q.push_back(16'h4201);
    n = 0;
    nres = 0;
    upd = 1'b0;
    @(negedge clk);
    bus.job_valid = 1'b1;
    bus.job_data  = 16'h4000;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (upd) begin
        bus.job_data  = 16'h4200;
        bus.job_valid = (n < 2);
        upd = 1'b0;
      end
      if (bus.job_ready && bus.job_valid && n < 2) begin
        acc[n] = cyc;
        n++;
        upd = 1'b1;
      end
      if (bus.res_valid) begin
        nres++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL b2b_extra: unexpected result %h", bus.res_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.res_data !== e) begin miscompares++; $display("FAIL b2b_order: got %h expected %h", bus.res_data, e); end
        end
      end
      @(negedge clk);
    end
    bus.job_valid = 1'b0;
    bus.res_ready = 1'b0;
    core_add = 1'b0;
    vectors += 3;
    if (nres !== 2) begin miscompares++; $display("FAIL b2b_count: got %0d results expected 2", nres); end
    if (n !== 2) begin
      miscompares++;
      $display("FAIL b2b_spacing: got %0d accepts expected 2", n);
    end else if (acc[1] - acc[0] !== 8) begin
      miscompares++;
      $display("FAIL b2b_spacing: got %0d expected 8", acc[1] - acc[0]);
    end
    if (mem[4] !== 8'h42) begin miscompares++; $display("FAIL b2b_mem4: got %h expected 42", mem[4]); end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_ack_last();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
